// File: rtl/uart_mmio_pkg.sv
// Shared register map and status-bit layout for the CPU-side UART bridge.
package uart_mmio_pkg;

  localparam logic [3:0] UART_STATUS = 4'h0;
  localparam logic [3:0] UART_RXDATA = 4'h4;
  localparam logic [3:0] UART_TXDATA = 4'h8;
  localparam logic [3:0] UART_CTRL   = 4'hC;

  localparam int TX_READY_BIT = 0;
  localparam int RX_VALID_BIT = 1;
  localparam int OVF_BIT      = 2;

  function automatic logic [31:0] statusWord(input logic txReady, input logic rxValid,
                                             input logic ovf);
    logic [31:0] w;
    w = '0;
    w[TX_READY_BIT] = txReady;
    w[RX_VALID_BIT] = rxValid;
    w[OVF_BIT]      = ovf;
    return w;
  endfunction

endpackage

// File: rtl/uart_mmio_bridge_if.sv
// Memory-stage I/O bus plus the UART byte handshakes, as seen by the bridge.
interface uart_mmio_bridge_if;

  logic        stall;
  logic        io_sel;
  logic [3:0]  io_addr;
  logic        io_re;
  logic        io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic [7:0]  DataIn;
  logic        DataInValid;
  logic        DataInReady;
  logic [7:0]  DataOut;
  logic        DataOutValid;
  logic        DataOutReady;

  modport master (
    output stall, io_sel, io_addr, io_re, io_we, io_wdata, DataInReady, DataOut, DataOutValid,
    input  io_rdata, DataIn, DataInValid, DataOutReady
  );

  modport slave (
    input  stall, io_sel, io_addr, io_re, io_we, io_wdata, DataInReady, DataOut, DataOutValid,
    output io_rdata, DataIn, DataInValid, DataOutReady
  );

endinterface

// File: rtl/uart_mmio_bridge_byte_fifo.sv
// Power-of-two byte FIFO with first-word-fall-through head and occupancy count.
module byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       wdata,
  output logic [7:0]       head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign head   = mem[rdPtr];

  // NOTE: storage is deliberately not reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wdata;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Load/store responder mapping CPU I/O accesses onto the UART TX/RX byte handshakes.
module uart_mmio_bridge
  import uart_mmio_pkg::*;
#(
  parameter  int RX_DEPTH = 4,
  localparam int PTR_W    = $clog2(RX_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  uart_mmio_bridge_if.slave  bus
);

  logic            rd;
  logic            wr;
  logic            txFire;
  logic            txAccept;
  logic            ovfClear;
  logic [31:0]     readData;
  logic [31:0]     rdataQ;
  logic [7:0]      dataInQ;
  logic            dataInValidQ;
  logic            overflow;
  logic            rxPush;
  logic            rxPop;
  logic [7:0]      rxHead;
  logic [PTR_W:0]  rxCount;
  logic            rxFull;
  logic            rxEmpty;

  // A simultaneous load+store is a store; loads never see a write-qualified cycle.
  assign wr = bus.io_sel & bus.io_we & ~bus.stall;
  assign rd = bus.io_sel & bus.io_re & ~bus.io_we & ~bus.stall;

  assign txFire   = dataInValidQ & bus.DataInReady;
  assign txAccept = wr & (bus.io_addr == UART_TXDATA) & (~dataInValidQ | txFire);
  assign ovfClear = wr & (bus.io_addr == UART_CTRL) & bus.io_wdata[OVF_BIT];

  assign rxPush = bus.DataOutValid & ~rxFull;
  assign rxPop  = rd & (bus.io_addr == UART_RXDATA) & ~rxEmpty;

  assign bus.io_rdata     = rdataQ;
  assign bus.DataIn       = dataInQ;
  assign bus.DataInValid  = dataInValidQ;
  assign bus.DataOutReady = ~rxFull;

  // NOTE: default assigned first so no path through the case leaves readData latched.
  always_comb begin
    readData = '0;
    case (bus.io_addr)
      UART_STATUS: readData = statusWord(~dataInValidQ, ~rxEmpty, overflow);
      UART_RXDATA: readData = {24'b0, rxEmpty ? 8'h00 : rxHead};
      default:     readData = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdataQ       <= '0;
      dataInQ      <= '0;
      dataInValidQ <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (rd) rdataQ <= readData;

      if (txAccept) begin
        dataInQ      <= bus.io_wdata[7:0];
        dataInValidQ <= 1'b1;
      end else if (txFire) begin
        dataInValidQ <= 1'b0;
      end

      // A blocked push outranks a same-cycle clear so no loss goes unreported.
      if (bus.DataOutValid & rxFull) overflow <= 1'b1;
      else if (ovfClear)             overflow <= 1'b0;
    end
  end

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rxFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rxPush),
    .pop   (rxPop),
    .wdata (bus.DataOut),
    .head  (rxHead),
    .count (rxCount),
    .full  (rxFull),
    .empty (rxEmpty)
  );

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Scenario bench for uart_mmio_bridge: read/TX expectations queued at stimulus time, compared on output.
module tb_uart_mmio_bridge;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] expQ[$];
  logic [7:0]  txExpQ[$];
  logic [7:0]  rxModel[$];

  uart_mmio_bridge_if bus ();

  uart_mmio_bridge #(.RX_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Every TX handshake must carry the next byte the bench expects to leave.
  always @(negedge clk) begin
    if (!rst && bus.DataInValid && bus.DataInReady) begin
      checks++;
      if (txExpQ.size() == 0) begin
        errors++;
        $display("FAIL tx_fire: unexpected byte %h, no byte expected", bus.DataIn);
      end else begin
        logic [7:0] e;
        e = txExpQ.pop_front();
        if (bus.DataIn !== e) begin
          errors++;
          $display("FAIL tx_fire: DataIn=%h expected %h", bus.DataIn, e);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic busRead(input logic [3:0] addr, input logic [31:0] exp,
                         output logic [31:0] obs, output logic [31:0] want);
    expQ.push_back(exp);
    bus.io_sel  = 1'b1;
    bus.io_re   = 1'b1;
    bus.io_addr = addr;
    cycle();
    bus.io_sel = 1'b0;
    bus.io_re  = 1'b0;
    obs  = bus.io_rdata;
    want = expQ.pop_front();
  endtask

  task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
    bus.io_sel   = 1'b1;
    bus.io_we    = 1'b1;
    bus.io_addr  = addr;
    bus.io_wdata = data;
    cycle();
    bus.io_sel = 1'b0;
    bus.io_we  = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] b);
    bus.DataOutValid = 1'b1;
    bus.DataOut      = b;
    if (rxModel.size() < DEPTH) rxModel.push_back(b);
    cycle();
    bus.DataOutValid = 1'b0;
  endtask

  function automatic logic [31:0] rxExpect();
    return (rxModel.size() != 0) ? {24'b0, rxModel.pop_front()} : 32'h0;
  endfunction

  task automatic test_reset();
    logic [31:0] obs, want;
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    checks++;
    if (bus.io_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: io_rdata=%h expected 0", bus.io_rdata);
    end
    checks++;
    if (bus.DataInValid !== 1'b0) begin
      errors++; $display("FAIL reset_txvalid: DataInValid=%b expected 0", bus.DataInValid);
    end
    checks++;
    if (bus.DataOutReady !== 1'b1) begin
      errors++; $display("FAIL reset_rxready: DataOutReady=%b expected 1", bus.DataOutReady);
    end
    busRead(4'h0, 32'h1, obs, want);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL reset_status: io_rdata=%h expected %h", obs, want);
    end
  endtask

  task automatic test_tx();
    logic [31:0] obs, want;
    bus.DataInReady = 1'b0;
    txExpQ.push_back(8'h7A);
    busWrite(4'h8, 32'hFFFF_FF7A);
    checks++;
    if (bus.DataInValid !== 1'b1 || bus.DataIn !== 8'h7A) begin
      errors++; $display("FAIL tx_load: valid=%b DataIn=%h expected 1/7a", bus.DataInValid, bus.DataIn);
    end
    busWrite(4'h8, 32'h55);
    checks++;
    if (bus.DataInValid !== 1'b1 || bus.DataIn !== 8'h7A) begin
      errors++; $display("FAIL tx_drop: valid=%b DataIn=%h expected 1/7a", bus.DataInValid, bus.DataIn);
    end
    busRead(4'h0, 32'h0, obs, want);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL tx_busy_status: io_rdata=%h expected %h", obs, want);
    end
    bus.DataInReady = 1'b1;
    cycle();
    bus.DataInReady = 1'b0;
    checks++;
    if (bus.DataInValid !== 1'b0) begin
      errors++; $display("FAIL tx_drain: DataInValid=%b expected 0", bus.DataInValid);
    end
    busRead(4'h0, 32'h1, obs, want);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL tx_idle_status: io_rdata=%h expected %h", obs, want);
    end
  endtask

  task automatic test_back_to_back();
    bus.DataInReady = 1'b1;
    txExpQ.push_back(8'h41);
    txExpQ.push_back(8'h42);
    busWrite(4'h8, 32'h41);
    checks++;
    if (bus.DataInValid !== 1'b1 || bus.DataIn !== 8'h41) begin
      errors++; $display("FAIL b2b_first: valid=%b DataIn=%h expected 1/41", bus.DataInValid, bus.DataIn);
    end
    busWrite(4'h8, 32'h42);
    checks++;
    if (bus.DataInValid !== 1'b1 || bus.DataIn !== 8'h42) begin
      errors++; $display("FAIL b2b_second: valid=%b DataIn=%h expected 1/42", bus.DataInValid, bus.DataIn);
    end
    cycle();
    bus.DataInReady = 1'b0;
    checks++;
    if (bus.DataInValid !== 1'b0 || txExpQ.size() != 0) begin
      errors++; $display("FAIL b2b_done: valid=%b pending=%0d expected 0/0", bus.DataInValid, txExpQ.size());
    end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] obs, want;
    for (int i = 0; i < 4; i++) pushByte(8'h10 + 8'(i));
    checks++;
    if (bus.DataOutReady !== 1'b0) begin
      errors++; $display("FAIL rx_full_ready: DataOutReady=%b expected 0", bus.DataOutReady);
    end
    busRead(4'h0, 32'h3, obs, want);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL rx_full_status: io_rdata=%h expected %h", obs, want);
    end
    pushByte(8'h14);
    busRead(4'h0, 32'h7, obs, want);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL rx_ovf_status: io_rdata=%h expected %h", obs, want);
    end
    for (int i = 0; i < 5; i++) begin
      busRead(4'h4, rxExpect(), obs, want);
      checks++;
      if (obs !== want) begin
        errors++; $display("FAIL rx_drain_%0d: io_rdata=%h expected %h", i, obs, want);
      end
    end
    busRead(4'h0, 32'h5, obs, want);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL rx_ovf_sticky: io_rdata=%h expected %h", obs, want);
    end
    busWrite(4'hC, 32'h4);
    busRead(4'h0, 32'h1, obs, want);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL rx_ovf_clear: io_rdata=%h expected %h", obs, want);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] obs, want;
    pushByte(8'h30);
    pushByte(8'h31);
    bus.DataOutValid = 1'b1;
    bus.DataOut      = 8'h20;
    want = rxExpect();
    rxModel.push_back(8'h20);
    busRead(4'h4, want, obs, want);
    bus.DataOutValid = 1'b0;
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL sim_head: io_rdata=%h expected %h", obs, want);
    end
    pushByte(8'h21);
    checks++;
    if (bus.DataOutReady !== 1'b1) begin
      errors++; $display("FAIL sim_count3: DataOutReady=%b expected 1", bus.DataOutReady);
    end
    pushByte(8'h22);
    checks++;
    if (bus.DataOutReady !== 1'b0) begin
      errors++; $display("FAIL sim_count4: DataOutReady=%b expected 0", bus.DataOutReady);
    end
    for (int i = 0; i < 5; i++) begin
      busRead(4'h4, rxExpect(), obs, want);
      checks++;
      if (obs !== want) begin
        errors++; $display("FAIL wrap_drain_%0d: io_rdata=%h expected %h", i, obs, want);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] obs, want;
    pushByte(8'h50);
    busRead(4'h0, 32'h3, obs, want);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL stall_pre: io_rdata=%h expected %h", obs, want);
    end
    bus.stall   = 1'b1;
    bus.io_sel  = 1'b1;
    bus.io_re   = 1'b1;
    bus.io_addr = 4'h4;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.io_rdata !== 32'h3) begin
        errors++; $display("FAIL stall_hold_%0d: io_rdata=%h expected 3", i, bus.io_rdata);
      end
    end
    bus.stall  = 1'b0;
    bus.io_sel = 1'b0;
    bus.io_re  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      busRead(4'h4, rxExpect(), obs, want);
      checks++;
      if (obs !== want) begin
        errors++; $display("FAIL stall_after_%0d: io_rdata=%h expected %h", i, obs, want);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] obs, want;
    bus.DataInReady = 1'b0;
    busWrite(4'h8, 32'h99);
    pushByte(8'h66);
    busRead(4'h0, 32'h2, obs, want);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL midop_pre: io_rdata=%h expected %h", obs, want);
    end
    rst = 1'b1;
    busRead(4'h0, 32'h0, obs, want);
    rst = 1'b0;
    rxModel.delete();
    checks++;
    if (obs !== want || bus.DataInValid !== 1'b0) begin
      errors++; $display("FAIL midop_reset: io_rdata=%h valid=%b expected %h/0", obs, bus.DataInValid, want);
    end
    busRead(4'h0, 32'h1, obs, want);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL midop_status: io_rdata=%h expected %h", obs, want);
    end
  endtask

  initial begin
    bus.stall        = 1'b0;
    bus.io_sel       = 1'b0;
    bus.io_addr      = 4'h0;
    bus.io_re        = 1'b0;
    bus.io_we        = 1'b0;
    bus.io_wdata     = 32'h0;
    bus.DataInReady  = 1'b0;
    bus.DataOut      = 8'h0;
    bus.DataOutValid = 1'b0;
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx_overflow();
    test_simultaneous();
    test_stall();
    test_reset_midop();
    repeat (2) cycle();
    checks++;
    if (txExpQ.size() != 0) begin
      errors++; $display("FAIL tx_pending: %0d bytes never sent, expected 0", txExpQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
- CPU-side responder for the serial link inside MIPS150.
- Maps load/store requests from the MIPS150 datapath onto the host-facing byte handshake of the UART block: transmit holding register, receive FIFO, and status register.
- Lets software running on the CPU answer the bytes a host drives into FPGA_SERIAL_RX and emit bytes on FPGA_SERIAL_TX.
- Sits between the memory-stage address decode (0x8000_00xx I/O region) and the UART instance.

Parameters:
- RX_DEPTH, 4, receive FIFO entries; power of two, at least 2.
- PTR_W, clog2(RX_DEPTH), FIFO pointer width (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  pipeline stall; while high, the request inputs are ignored.
- io_sel  in  1  memory stage addresses the UART window.
- io_addr  in  4  byte offset within the window: 0x0, 0x4, 0x8 or 0xC.
- io_re  in  1  load request.
- io_we  in  1  store request.
- io_wdata  in  32  store data; only bits [7:0] are used.
- io_rdata  out  32  load data, registered.
- DataIn  out  8  byte to UART transmitter.
- DataInValid  out  1  DataIn is valid.
- DataInReady  in  1  UART transmitter accepts the byte.
- DataOut  in  8  byte from UART receiver.
- DataOutValid  in  1  received byte is valid.
- DataOutReady  out  1  bridge accepts the received byte.

Behaviour:
- Request qualifiers:
  - rd = io_sel & io_re & ~stall.
  - wr = io_sel & io_we & ~stall.
  - A request with both io_re and io_we high is treated as a write only.
- Reset values: io_rdata=0, DataIn=0, DataInValid=0, RX FIFO empty (count 0, pointers 0), overflow=0. DataOutReady=1 after reset, because the FIFO is empty.
- Register map:
  - 0x0 STATUS (read): bit0 tx_ready = ~DataInValid; bit1 rx_valid = (count != 0); bit2 overflow; bits[31:3]=0.
  - 0x4 RXDATA (read): {24'b0, FIFO head}. If the FIFO is non-empty, the read pops it. If empty, it returns 0 and has no side effect.
  - 0x8 TXDATA (write): loads the byte.
  - 0xC CTRL (write): a 1 in bit2 clears overflow.
  - Reads of 0x8 or 0xC return 0. Writes to 0x0 or 0x4 are ignored.
- Read latency: exactly 1 cycle. io_rdata reflects state sampled in the request cycle, before that cycle's updates. Without rd, io_rdata holds its value; this includes while stalled.
- TX handshake:
  - fire = DataInValid & DataInReady.
  - A TXDATA write is accepted when ~DataInValid | fire. On acceptance: DataIn <= wdata[7:0] and DataInValid <= 1 on the next cycle.
  - fire without an accepted write: DataInValid <= 0.
  - A TXDATA write while the holding register is full and not firing is silently dropped; DataIn is unchanged.
  - DataIn stays stable while DataInValid is high.
- RX FIFO:
  - push = DataOutValid & DataOutReady.
  - DataOutReady = (count != RX_DEPTH), driven from the registered count.
  - pop = RXDATA read & (count != 0).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo RX_DEPTH.
  - When full: push is blocked. If DataOutValid is high in that cycle, overflow <= 1. The flag is sticky until a CTRL clear or rst.
  - If a CTRL clear and an overflow event occur in the same cycle, the set wins.
- Reset mid-operation: a pending TX byte is discarded (DataInValid drops the cycle after rst), FIFO contents are lost, and any load in flight returns 0.
- No combinational path from io_* inputs to any output.

Decomposition:
- Shared package uart_mmio_pkg:
  - Offsets UART_STATUS=4'h0, UART_RXDATA=4'h4, UART_TXDATA=4'h8, UART_CTRL=4'hC.
  - Status bit indices TX_READY_BIT=0, RX_VALID_BIT=1, OVF_BIT=2.
- One sub-module: byte_fifo (parameterized depth, 8-bit data, push/pop/count/full/empty), instantiated for RX.
- TX holding register and decode stay in the top level.

Test Plan:
- Reset: assert rst for 3 cycles, then read STATUS -> io_rdata=0x1 one cycle later; DataInValid=0; DataOutReady=1.
- TX: write 0x7A to 0x8 with DataInReady=0 -> DataIn=0x7A, DataInValid=1 next cycle. Then write 0x55 -> dropped, DataIn stays 0x7A. Raise DataInReady for 1 cycle -> DataInValid=0 next cycle.
- TX back-to-back: hold DataInReady=1 and write 0x41, 0x42 on consecutive cycles -> two fires carrying 0x41 then 0x42 in order; DataInValid never drops between them.
- RX fill/overflow:
  - Push 0x10,0x11,0x12,0x13 -> DataOutReady=0 and STATUS=0x3.
  - Push 0x14 -> blocked, STATUS=0x7.
  - Four RXDATA reads -> 0x10..0x13 in order; fifth read -> 0x0.
  - Write 0x4 to 0xC -> STATUS=0x1.
- Simultaneous: with 2 entries, push 0x20 in the same cycle as an RXDATA pop -> returns the old head, count stays 2; wrap checked after 9 total pushes.
- Stall: io_re=1 on RXDATA with stall=1 for 3 cycles -> no pop, io_rdata unchanged, count unchanged.
